// File: rtl/gfx_strip_packer.sv
// Pixel-to-strip packer: packs one pixel per cycle LSB-first into STRIP_WIDTH-bit strips
// with byte enables, and buffers completed strips in a small show-ahead FIFO.
// Optional 4bpp mode (depth code 4) is enabled by defining GFX_STRIP_PACKER_BPP4_EN.
module gfx_strip_packer #(
  parameter int unsigned STRIP_WIDTH = 128,
  parameter int unsigned MAX_BPP     = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2:0]               cfg_depth_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  input  logic [MAX_BPP-1:0]       pix_data_i,
  input  logic                     pix_last_i,
  output logic                     strip_valid_o,
  input  logic                     strip_ready_i,
  output logic [STRIP_WIDTH-1:0]   strip_data_o,
  output logic [STRIP_WIDTH/8-1:0] strip_mask_o,
  output logic                     strip_last_o,
  output logic                     busy_o,
  output logic                     cfg_err_o
);

  localparam int unsigned MaskW = STRIP_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(STRIP_WIDTH / 4 + 1);
  localparam int unsigned FcW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdxW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StAccum, StPush} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [5:0]             bpp_q, bpp_d;
  logic [STRIP_WIDTH-1:0] acc_q, acc_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [5:0]             dec_bpp;
  logic                   dec_err;
  logic [5:0]             bpp_eff;
  logic [CntW-1:0]        pps_eff;
  logic [CntW-1:0]        count_inc;
  logic [15:0]            bit_pos;
  logic [STRIP_WIDTH-1:0] pix_field;
  logic [STRIP_WIDTH-1:0] pix_ext;
  logic [15:0]            nbytes;
  logic [MaskW-1:0]       mask_w;

  logic [STRIP_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [MaskW-1:0]       fifo_mask [FIFO_DEPTH];
  logic                   fifo_last [FIFO_DEPTH];
  logic [FcW-1:0]         fcnt_q, fcnt_d;
  logic [IdxW-1:0]        widx;
  logic                   full, pop, push;

  // Decode the depth code; unsupported codes fall back to 8bpp and flag an error.
  always_comb begin
    dec_bpp = 6'd8;
    dec_err = 1'b0;
    case (cfg_depth_i)
      3'd0: dec_bpp = 6'd8;
      3'd1: dec_bpp = 6'd16;
      3'd2: dec_bpp = 6'd24;
      3'd3: dec_bpp = 6'd32;
`ifdef GFX_STRIP_PACKER_BPP4_EN
      3'd4: dec_bpp = 6'd4;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  // Depth in force for the current pixel: live code on the first pixel, latched afterwards.
  always_comb begin
    bpp_eff = (count_q == '0) ? dec_bpp : bpp_q;
    case (bpp_eff)
      6'd4:    pps_eff = CntW'(STRIP_WIDTH / 4);
      6'd16:   pps_eff = CntW'(STRIP_WIDTH / 16);
      6'd24:   pps_eff = CntW'(STRIP_WIDTH / 24);
      6'd32:   pps_eff = CntW'(STRIP_WIDTH / 32);
      default: pps_eff = CntW'(STRIP_WIDTH / 8);
    endcase
  end

  // Place the incoming pixel at its slot, masking off bits above the active depth.
  always_comb begin
    count_inc = count_q + CntW'(1);
    bit_pos   = 16'(count_q) * 16'(bpp_eff);
    pix_field = (STRIP_WIDTH'(1) << bpp_eff) - STRIP_WIDTH'(1);
    pix_ext   = STRIP_WIDTH'(pix_data_i) & pix_field;
  end

  // Byte enables cover every byte touched by a written pixel.
  always_comb begin
    nbytes = (16'(count_q) * 16'(bpp_q) + 16'd7) >> 3;
    mask_w = '0;
    for (int j = 0; j < MaskW; j++) begin
      mask_w[j] = (16'(j) < nbytes);
    end
  end

  // FIFO handshake; a push is allowed into a full FIFO when a pop frees a slot the same cycle.
  always_comb begin
    strip_valid_o = (fcnt_q != '0);
    full          = (fcnt_q == FcW'(FIFO_DEPTH));
    pop           = strip_valid_o && strip_ready_i;
    push          = (state_q == StPush) && (!full || pop);
    widx          = pop ? IdxW'(fcnt_q - FcW'(1)) : IdxW'(fcnt_q);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FcW'(1);
      2'b01:   fcnt_d = fcnt_q - FcW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Packer FSM next-state and pixel handshake.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bpp_d       = bpp_q;
    acc_d       = acc_q;
    last_d      = last_q;
    err_d       = 1'b0;
    pix_ready_o = 1'b0;
    case (state_q)
      StIdle, StAccum: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          count_d = count_inc;
          acc_d   = acc_q | (pix_ext << bit_pos);
          last_d  = pix_last_i;
          if (count_q == '0) begin
            bpp_d = dec_bpp;
            err_d = dec_err;
          end
          state_d = (count_inc == pps_eff || pix_last_i) ? StPush : StAccum;
        end
      end
      StPush: begin
        if (push) begin
          state_d = StIdle;
          count_d = '0;
          acc_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      bpp_q   <= 6'd8;
      acc_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bpp_q   <= bpp_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_mask[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_data[i] <= fifo_data[i+1];
          fifo_mask[i] <= fifo_mask[i+1];
          fifo_last[i] <= fifo_last[i+1];
        end
        fifo_data[FIFO_DEPTH-1] <= '0;
        fifo_mask[FIFO_DEPTH-1] <= '0;
        fifo_last[FIFO_DEPTH-1] <= 1'b0;
      end
      if (push) begin
        fifo_data[widx] <= acc_q;
        fifo_mask[widx] <= mask_w;
        fifo_last[widx] <= last_q;
      end
      fcnt_q <= fcnt_d;
    end
  end

  // Head strip and status outputs.
  always_comb begin
    strip_data_o = fifo_data[0];
    strip_mask_o = fifo_mask[0];
    strip_last_o = fifo_last[0];
    busy_o       = (state_q != StIdle) || (fcnt_q != '0);
    cfg_err_o    = err_q;
  end

endmodule

// File: tb/tb_gfx_strip_packer.sv
// Self-checking bench for gfx_strip_packer (STRIP_WIDTH=128, MAX_BPP=32, FIFO_DEPTH=4).
// Table vectors, hand-written corner sequences and a randomized run against a strip-level model.
module tb_gfx_strip_packer;

  localparam int SW = 128;
  localparam int MW = SW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [2:0]    cfg_depth_i = 3'd0;
  logic          pix_valid_i = 1'b0;
  logic          pix_ready_o;
  logic [31:0]   pix_data_i = '0;
  logic          pix_last_i = 1'b0;
  logic          strip_valid_o;
  logic          strip_ready_i = 1'b0;
  logic [SW-1:0] strip_data_o;
  logic [MW-1:0] strip_mask_o;
  logic          strip_last_o;
  logic          busy_o;
  logic          cfg_err_o;

  gfx_strip_packer #(.STRIP_WIDTH(SW), .MAX_BPP(32), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_depth_i   (cfg_depth_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .pix_data_i    (pix_data_i),
    .pix_last_i    (pix_last_i),
    .strip_valid_o (strip_valid_o),
    .strip_ready_i (strip_ready_i),
    .strip_data_o  (strip_data_o),
    .strip_mask_o  (strip_mask_o),
    .strip_last_o  (strip_last_o),
    .busy_o        (busy_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (strip level) ----------------
  typedef struct {
    logic [SW-1:0] data;
    logic [MW-1:0] mask;
    logic          last;
  } strip_t;

  strip_t      exp_q[$];
  logic [31:0] cur_pix[$];
  int          cur_bpp, cur_pps;
  int          exp_errs = 0;

  function automatic void decode(input int code, output int bpp, output bit err);
    err = 1'b0;
    case (code)
      0: bpp = 8;
      1: bpp = 16;
      2: bpp = 24;
      3: bpp = 32;
`ifdef GFX_STRIP_PACKER_BPP4_EN
      4: bpp = 4;
`endif
      default: begin bpp = 8; err = 1'b1; end
    endcase
  endfunction

  function automatic void model_emit(input bit last);
    strip_t s;
    logic [SW-1:0] field;
    int n, nb;
    n = cur_pix.size();
    field = (SW'(1) << cur_bpp) - SW'(1);
    s.data = '0;
    for (int k = 0; k < n; k++) s.data = s.data | ((SW'(cur_pix[k]) & field) << (k * cur_bpp));
    nb = (n * cur_bpp + 7) / 8;
    s.mask = '0;
    for (int j = 0; j < MW; j++) s.mask[j] = (j < nb);
    s.last = last;
    exp_q.push_back(s);
    cur_pix.delete();
  endfunction

  function automatic void model_accept(input int code, input logic [31:0] d, input bit last);
    bit err;
    if (cur_pix.size() == 0) begin
      decode(code, cur_bpp, err);
      cur_pps = SW / cur_bpp;
      if (err) exp_errs++;
    end
    cur_pix.push_back(d);
    if (cur_pix.size() == cur_pps || last) model_emit(last);
  endfunction

  function automatic void model_reset();
    cur_pix.delete();
    exp_q.delete();
  endfunction

  // ---------------- monitor: sampled on the falling edge ----------------
  int            pops = 0;
  int            err_seen = 0;
  logic [SW-1:0] pop_data;
  logic [MW-1:0] pop_mask;
  logic          pop_last;
  logic          hold_v = 1'b0;
  logic [SW-1:0] hold_d;

  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_v = 1'b0;
    end else begin
      if (cfg_err_o) err_seen++;
      if (pix_valid_i && pix_ready_o) model_accept(int'(cfg_depth_i), pix_data_i, pix_last_i);
      if (hold_v && strip_valid_o) chk("head_stable", strip_data_o, hold_d);
      hold_v = strip_valid_o && !strip_ready_i;
      hold_d = strip_data_o;
      if (strip_valid_o && strip_ready_i) begin
        pops++;
        pop_data = strip_data_o;
        pop_mask = strip_mask_o;
        pop_last = strip_last_o;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strip: got %0h expected no strip", strip_data_o);
        end else begin
          strip_t e;
          e = exp_q.pop_front();
          chk("model_data", strip_data_o, e.data);
          chk("model_mask", SW'(strip_mask_o), SW'(e.mask));
          chk("model_last", SW'(strip_last_o), SW'(e.last));
        end
      end
    end
  end

  // ---------------- drivers (called just after a rising edge) ----------------
  bit rand_ready_en = 1'b0;
  always @(posedge clk_i) begin
    if (rand_ready_en) begin
      #1;
      strip_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] d, input bit last);
    int n = 0;
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    pix_last_i  = last;
    forever begin
      @(negedge clk_i);
      if (pix_ready_o) break;
      n++;
      if (n > 500) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 500 cycles");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    pix_valid_i = 1'b0;
    pix_last_i  = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk("pop_count", SW'(pops), SW'(target));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    cycles(2);
    rst_i = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [2:0]    depth;
    int            n;
    logic [31:0]   first;
    logic [31:0]   step;
    bit            last;
    logic [SW-1:0] data;
    logic [MW-1:0] mask;
    bit            err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int p0, e0;
    vecs[0]  = '{3'd1, 8, 32'h1, 32'h1, 1'b0,
                 128'h0008_0007_0006_0005_0004_0003_0002_0001, 16'hFFFF, 1'b0};
    vecs[1]  = '{3'd2, 5, 32'h111111, 32'h111111, 1'b0,
                 128'h0055_5555_4444_4433_3333_2222_2211_1111, 16'h7FFF, 1'b0};
    vecs[2]  = '{3'd2, 1, 32'h666666, 32'h0, 1'b1, 128'h666666, 16'h0007, 1'b0};
    vecs[3]  = '{3'd0, 16, 32'hA0, 32'h1, 1'b0,
                 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0, 16'hFFFF, 1'b0};
    vecs[4]  = '{3'd3, 4, 32'hDEADBEEF, 32'h0, 1'b0,
                 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16'hFFFF, 1'b0};
    vecs[5]  = '{3'd0, 3, 32'h12345678, 32'h1, 1'b1, 128'h7A7978, 16'h0007, 1'b0};
    vecs[6]  = '{3'd1, 3, 32'hABCD0001, 32'h1, 1'b1, 128'h0003_0002_0001, 16'h003F, 1'b0};
    vecs[7]  = '{3'd3, 1, 32'hCAFEF00D, 32'h0, 1'b1, 128'hCAFEF00D, 16'h000F, 1'b0};
    vecs[8]  = '{3'd5, 2, 32'h11, 32'h11, 1'b1, 128'h2211, 16'h0003, 1'b1};
`ifdef GFX_STRIP_PACKER_BPP4_EN
    vecs[9]  = '{3'd4, 3, 32'h1, 32'h1, 1'b1, 128'h321, 16'h0003, 1'b0};
`else
    vecs[9]  = '{3'd4, 3, 32'h1, 32'h1, 1'b1, 128'h030201, 16'h0007, 1'b1};
`endif
    vecs[10] = '{3'd3, 4, 32'h01020304, 32'h01010101, 1'b1,
                 128'h04050607_03040506_02030405_01020304, 16'hFFFF, 1'b0};

    // Reset state
    cycles(3);
    rst_i = 1'b0;
    chk("rst_strip_valid", SW'(strip_valid_o), '0);
    chk("rst_pix_ready", SW'(pix_ready_o), SW'(1));
    chk("rst_busy", SW'(busy_o), '0);
    chk("rst_cfg_err", SW'(cfg_err_o), '0);
    chk("rst_data", strip_data_o, '0);
    chk("rst_mask", SW'(strip_mask_o), '0);

    // Table-driven single-strip vectors
    strip_ready_i = 1'b1;
    foreach (vecs[v]) begin
      cfg_depth_i = vecs[v].depth;
      p0 = pops;
      e0 = err_seen;
      for (int k = 0; k < vecs[v].n; k++)
        send(vecs[v].first + vecs[v].step * 32'(k), vecs[v].last && (k == vecs[v].n - 1));
      wait_pops(p0 + 1, 20);
      chk($sformatf("vec%0d_data", v), pop_data, vecs[v].data);
      chk($sformatf("vec%0d_mask", v), SW'(pop_mask), SW'(vecs[v].mask));
      chk($sformatf("vec%0d_last", v), SW'(pop_last), SW'(vecs[v].last));
      cycles(2);
      chk($sformatf("vec%0d_err", v), SW'(err_seen - e0), SW'(vecs[v].err));
    end

    // Latency: strip completed in cycle N, head valid in N+2
    strip_ready_i = 1'b0;
    cfg_depth_i = 3'd1;
    p0 = pops;
    for (int k = 1; k <= 8; k++) send(32'(k), 1'b0);
    chk("lat_n1_valid", SW'(strip_valid_o), '0);
    chk("lat_n1_pix_ready", SW'(pix_ready_o), '0);
    chk("lat_n1_busy", SW'(busy_o), SW'(1));
    cycles(1);
    chk("lat_n2_valid", SW'(strip_valid_o), SW'(1));
    chk("lat_n2_mask", SW'(strip_mask_o), SW'(16'hFFFF));
    cycles(3);
    strip_ready_i = 1'b1;
    wait_pops(p0 + 1, 10);

    // Backpressure: 5 strips of 32bpp against a 4-entry FIFO
    strip_ready_i = 1'b0;
    cfg_depth_i = 3'd3;
    p0 = pops;
    for (int k = 0; k < 20; k++) send(32'h5000_0000 + 32'(k), 1'b0);
    cycles(3);
    chk("full_pix_ready", SW'(pix_ready_o), '0);
    chk("full_valid", SW'(strip_valid_o), SW'(1));
    chk("full_busy", SW'(busy_o), SW'(1));
    chk("full_head", strip_data_o, 128'h50000003_50000002_50000001_50000000);
    strip_ready_i = 1'b1;
    wait_pops(p0 + 5, 40);

    // Reset mid-strip discards the partial strip
    cfg_depth_i = 3'd0;
    for (int k = 0; k < 3; k++) send(32'h55, 1'b0);
    do_reset();
    chk("midrst_valid", SW'(strip_valid_o), '0);
    chk("midrst_busy", SW'(busy_o), '0);
    chk("midrst_pix_ready", SW'(pix_ready_o), SW'(1));
    p0 = pops;
    for (int k = 0; k < 16; k++) send(32'hA0 + 32'(k), 1'b0);
    wait_pops(p0 + 1, 20);
    chk("midrst_data", pop_data, 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0);
    chk("midrst_mask", SW'(pop_mask), SW'(16'hFFFF));
    cycles(5);
    chk("midrst_one_strip", SW'(pops), SW'(p0 + 1));

    // Depth change mid-strip is ignored until the next strip
    p0 = pops;
    cfg_depth_i = 3'd0;
    send(32'h10, 1'b0);
    send(32'h11, 1'b0);
    cfg_depth_i = 3'd1;
    for (int k = 2; k < 16; k++) send(32'h10 + 32'(k), 1'b0);
    wait_pops(p0 + 1, 20);
    chk("switch_data0", pop_data, 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110);
    for (int k = 0; k < 8; k++) send(32'(k), 1'b0);
    wait_pops(p0 + 2, 20);
    chk("switch_data1", pop_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Randomized traffic against the model
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cfg_depth_i = 3'($urandom_range(0, 7));
      send($urandom, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    send($urandom, 1'b1);
    rand_ready_en = 1'b0;
    @(posedge clk_i);
    #2;
    strip_ready_i = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
        @(posedge clk_i);
        n++;
      end
    end
    cycles(3);
    chk("rand_drained", SW'(exp_q.size()), '0);
    chk("rand_idle_busy", SW'(busy_o), '0);
    chk("cfg_err_pulses", SW'(err_seen), SW'(exp_errs));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
